ctrl_pipe_unit: RTL and testbench
=================================

// Module: ctrl_pipe_unit
// PURPOSE
//  Pipelined control unit for the 5-stage RV32I core: decodes op/funct3/funct7b5 in ID and
//  carries the control word through ID/EX, EX/MEM and MEM/WB registers with stall/flush.
//  Extends the single-cycle main decoder with an ALU-decode subset, optional JAL/JALR/LUI
//  support, illegal-instruction detection and a saturating illegal-instruction counter.
// PARAMETERS
//  ENABLE_JUMPS  1   1: JAL/JALR decoded; 0: both treated as illegal
//  ENABLE_UPPER  1   1: LUI decoded; 0: treated as illegal
//  CNT_W         16  width of illegal_cnt (saturating)
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous active-low reset
//  instr_valid_d in   1      ID holds a real instruction (0 = bubble, decode forced to zero)
//  op_d          in   7      opcode, ID stage
//  funct3_d      in   3      funct3, ID stage
//  funct7b5_d    in   1      instr[30], ID stage
//  stall_e       in   1      hold ID/EX register (hazard unit)
//  flush_e       in   1      load bubble into ID/EX (branch taken / load-use)
//  imm_src_d     out  3      combinational: 000 I, 001 S, 010 B, 011 J, 100 U
//  illegal_d     out  1      combinational: valid && unsupported encoding
//  reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e  out 1 each, EX stage
//  alu_ctrl_e    out  3      000 add, 001 sub, 010 and, 011 or, 101 slt
//  result_src_e  out  2      00 ALU, 01 mem, 10 PC+4, 11 imm (LUI)
//  reg_write_m, mem_write_m out 1; result_src_m out 2   MEM stage
//  reg_write_w   out  1;     result_src_w  out  2       WB stage
//  illegal_cnt   out  CNT_W  count of illegal instructions accepted into EX
// BEHAVIOUR
//  Reset: every registered output and illegal_cnt = 0 immediately on rst_n low; mid-op reset
//   discards all in-flight control words.
//  Decode (ID, combinational; outputs all 0 unless listed):
//   LW  0000011 f3=010: reg_write, alu_src, result_src=01, imm I, alu add
//   SW  0100011 f3=010: mem_write, alu_src, imm S, alu add
//   R   0110011: reg_write, alu from funct3/funct7b5; f3 000+b5=1 -> sub
//   I   0010011: reg_write, alu_src, imm I; f3 000 always add (b5 ignored)
//   ALU f3 map (R and I): 000 add/sub, 010 slt, 110 or, 111 and; any other f3 -> illegal
//   BEQ 1100011 f3=000: branch, imm B, alu sub
//   JAL 1101111: reg_write, jump, result_src=10, imm J
//   JALR 1100111 f3=000: reg_write, jump, jalr, alu_src, result_src=10, imm I, alu add
//   LUI 0110111: reg_write, result_src=11, imm U
//   Any other op, wrong funct3, or disabled feature -> illegal_d=1, control word all 0.
//   instr_valid_d=0 -> control word all 0, illegal_d=0.
//  ID/EX update per cycle, priority: flush_e (load all 0) > stall_e (hold) > load decode.
//  EX/MEM, MEM/WB always advance; stall_e does not freeze them (hazard unit bubbles EX).
//  Latency: word decoded in ID at cycle n visible at *_e n+1, *_m n+2, *_w n+3.
//  illegal_cnt: +1 on edge where illegal_d && !stall_e && !flush_e; saturates at 2^CNT_W-1.
//  Simultaneous stall_e && flush_e: flush wins, counter not incremented.
//  imm_src_d is valid even when stall_e=1 (combinational on ID inputs).
// TESTING
//  Reset: assert rst_n=0 mid-stream with reg_write_w=1 -> all outputs 0 same cycle, cnt=0.
//  Pipeline: LW(f3=010) then ADD at cycles 0,1 -> result_src_e=01@1, _m=01@2, _w=01@3;
//   reg_write_w=1 @3 and @4.
//  SUB vs ADDI: R f3=000 b5=1 -> alu_ctrl_e=001; I f3=000 b5=1 -> alu_ctrl_e=000.
//  Stall/flush: stall_e=1 2 cycles holds EX word, MEM gets duplicates; stall+flush same
//   cycle -> EX word all 0.
//  Illegal: op=1111111 x3, plus JAL with ENABLE_JUMPS=0 -> illegal_cnt=4, word zero;
//   CNT_W=2 with 5 illegal -> illegal_cnt=3.
//  Jumps: JALR f3=000 -> jump_e=1, jalr_e=1, result_src_e=10, imm_src_d=000; f3=001 -> illegal.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// Control-pipe bus: ID-stage decode inputs and hazard controls in, staged control word out.
interface ctrl_pipe_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid_d;
  logic [6:0]       op_d;
  logic [2:0]       funct3_d;
  logic             funct7b5_d;
  logic             stall_e;
  logic             flush_e;
  logic [2:0]       imm_src_d;
  logic             illegal_d;
  logic             reg_write_e;
  logic             mem_write_e;
  logic             branch_e;
  logic             jump_e;
  logic             jalr_e;
  logic             alu_src_e;
  logic [2:0]       alu_ctrl_e;
  logic [1:0]       result_src_e;
  logic             reg_write_m;
  logic             mem_write_m;
  logic [1:0]       result_src_m;
  logic             reg_write_w;
  logic [1:0]       result_src_w;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output instr_valid_d, op_d, funct3_d, funct7b5_d, stall_e, flush_e,
    input  imm_src_d, illegal_d, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e,
           alu_src_e, alu_ctrl_e, result_src_e, reg_write_m, mem_write_m, result_src_m,
           reg_write_w, result_src_w, illegal_cnt
  );

  modport slave (
    input  instr_valid_d, op_d, funct3_d, funct7b5_d, stall_e, flush_e,
    output imm_src_d, illegal_d, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e,
           alu_src_e, alu_ctrl_e, result_src_e, reg_write_m, mem_write_m, result_src_m,
           reg_write_w, result_src_w, illegal_cnt
  );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// RV32I pipelined control unit: ID decode, ID/EX (stall/flush), EX/MEM, MEM/WB control
// registers and a saturating illegal-instruction counter.
module ctrl_pipe_unit #(
  parameter bit ENABLE_JUMPS = 1'b1,
  parameter bit ENABLE_UPPER = 1'b1,
  parameter int CNT_W        = 16
) (
  input logic         clk,
  input logic         rst_n,
  ctrl_pipe_if.slave  bus
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic [1:0] result_src;
  } ctrl_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // Returns {bad, alu_ctrl} for the shared R/I funct3 map.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_decode = {1'b0, sub ? 3'b001 : 3'b000};
      3'b010:  alu_decode = 4'b0101;
      3'b110:  alu_decode = 4'b0011;
      3'b111:  alu_decode = 4'b0010;
      default: alu_decode = 4'b1000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  ctrl_t      w_dec;
  ctrl_t      w_word;
  logic [2:0] w_imm;
  logic       w_bad;
  logic [3:0] w_alu;

  always_comb begin
    w_dec = '0;
    w_imm = 3'b000;
    w_bad = 1'b0;
    w_alu = 4'b0000;
    if (bus.instr_valid_d) begin
      case (bus.op_d)
        OP_LW: begin
          w_bad = (bus.funct3_d != 3'b010);
          w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.result_src = 2'b01;
        end
        OP_SW: begin
          w_bad = (bus.funct3_d != 3'b010);
          w_dec.mem_write = 1'b1; w_dec.alu_src = 1'b1; w_imm = 3'b001;
        end
        OP_R: begin
          w_alu = alu_decode(bus.funct3_d, bus.funct7b5_d);
          w_bad = w_alu[3];
          w_dec.reg_write = 1'b1; w_dec.alu_ctrl = w_alu[2:0];
        end
        OP_I: begin
          // funct7b5 is immediate data for ADDI, so never select subtract here
          w_alu = alu_decode(bus.funct3_d, 1'b0);
          w_bad = w_alu[3];
          w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu_ctrl = w_alu[2:0];
        end
        OP_BEQ: begin
          w_bad = (bus.funct3_d != 3'b000);
          w_dec.branch = 1'b1; w_dec.alu_ctrl = 3'b001; w_imm = 3'b010;
        end
        OP_JAL: begin
          w_bad = !ENABLE_JUMPS;
          w_dec.reg_write = 1'b1; w_dec.jump = 1'b1; w_dec.result_src = 2'b10; w_imm = 3'b011;
        end
        OP_JALR: begin
          w_bad = !ENABLE_JUMPS || (bus.funct3_d != 3'b000);
          w_dec.reg_write = 1'b1; w_dec.jump = 1'b1; w_dec.jalr = 1'b1;
          w_dec.alu_src = 1'b1; w_dec.result_src = 2'b10;
        end
        OP_LUI: begin
          w_bad = !ENABLE_UPPER;
          w_dec.reg_write = 1'b1; w_dec.result_src = 2'b11; w_imm = 3'b100;
        end
        default: w_bad = 1'b1;
      endcase
    end
  end

  assign w_word        = w_bad ? '0 : w_dec;
  assign bus.imm_src_d = w_bad ? 3'b000 : w_imm;
  assign bus.illegal_d = w_bad;

  ctrl_t            r_ex_p1;
  logic [3:0]       r_mem_p2;
  logic [2:0]       r_wb_p3;
  logic [CNT_W-1:0] r_cnt;

  // ID/EX boundary: flush beats stall beats load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_p1 <= '0;
      r_cnt   <= '0;
    end else begin
      if (bus.flush_e)       r_ex_p1 <= '0;
      else if (!bus.stall_e) r_ex_p1 <= w_word;
      if (w_bad && !bus.stall_e && !bus.flush_e) r_cnt <= sat_inc(r_cnt);
    end
  end

  // EX/MEM and MEM/WB boundaries advance every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_p2 <= '0;
      r_wb_p3  <= '0;
    end else begin
      r_mem_p2 <= {r_ex_p1.reg_write, r_ex_p1.mem_write, r_ex_p1.result_src};
      r_wb_p3  <= {r_mem_p2[3], r_mem_p2[1:0]};
    end
  end

  assign bus.reg_write_e  = r_ex_p1.reg_write;
  assign bus.mem_write_e  = r_ex_p1.mem_write;
  assign bus.branch_e     = r_ex_p1.branch;
  assign bus.jump_e       = r_ex_p1.jump;
  assign bus.jalr_e       = r_ex_p1.jalr;
  assign bus.alu_src_e    = r_ex_p1.alu_src;
  assign bus.alu_ctrl_e   = r_ex_p1.alu_ctrl;
  assign bus.result_src_e = r_ex_p1.result_src;
  assign bus.reg_write_m  = r_mem_p2[3];
  assign bus.mem_write_m  = r_mem_p2[2];
  assign bus.result_src_m = r_mem_p2[1:0];
  assign bus.reg_write_w  = r_wb_p3[2];
  assign bus.result_src_w = r_wb_p3[1:0];
  assign bus.illegal_cnt  = r_cnt;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: full-feature unit, jumps/upper disabled unit, 2-bit counter unit.
module tb_ctrl_pipe_unit;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld, b5, stall, flush;
  logic [6:0] op;
  logic [2:0] f3;
  int         checks = 0;
  int         errors = 0;

  ctrl_pipe_if #(.CNT_W(16)) if0 ();
  ctrl_pipe_if #(.CNT_W(16)) if1 ();
  ctrl_pipe_if #(.CNT_W(2))  if2 ();

  ctrl_pipe_unit #(.ENABLE_JUMPS(1'b1), .ENABLE_UPPER(1'b1), .CNT_W(16))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  ctrl_pipe_unit #(.ENABLE_JUMPS(1'b0), .ENABLE_UPPER(1'b0), .CNT_W(16))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  ctrl_pipe_unit #(.ENABLE_JUMPS(1'b1), .ENABLE_UPPER(1'b1), .CNT_W(2))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  assign if0.instr_valid_d = vld;  assign if1.instr_valid_d = vld;  assign if2.instr_valid_d = vld;
  assign if0.op_d = op;            assign if1.op_d = op;            assign if2.op_d = op;
  assign if0.funct3_d = f3;        assign if1.funct3_d = f3;        assign if2.funct3_d = f3;
  assign if0.funct7b5_d = b5;      assign if1.funct7b5_d = b5;      assign if2.funct7b5_d = b5;
  assign if0.stall_e = stall;      assign if1.stall_e = stall;      assign if2.stall_e = stall;
  assign if0.flush_e = flush;      assign if1.flush_e = flush;      assign if2.flush_e = flush;

  logic [10:0] ex0, ex1;
  logic [3:0]  mem0;
  logic [2:0]  wb0;
  assign ex0  = {if0.reg_write_e, if0.mem_write_e, if0.branch_e, if0.jump_e, if0.jalr_e,
                 if0.alu_src_e, if0.alu_ctrl_e, if0.result_src_e};
  assign ex1  = {if1.reg_write_e, if1.mem_write_e, if1.branch_e, if1.jump_e, if1.jalr_e,
                 if1.alu_src_e, if1.alu_ctrl_e, if1.result_src_e};
  assign mem0 = {if0.reg_write_m, if0.mem_write_m, if0.result_src_m};
  assign wb0  = {if0.reg_write_w, if0.result_src_w};

  always #5 clk = ~clk;

  function automatic logic [10:0] ew(input logic rw, input logic mw, input logic br,
                                     input logic j, input logic jr, input logic as,
                                     input logic [2:0] alu, input logic [1:0] rs);
    ew = {rw, mw, br, j, jr, as, alu, rs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f,
                       input logic b, input logic s, input logic fl);
    vld = v; op = o; f3 = f; b5 = b; stall = s; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_ex", ex0, 0);
    chk("rst_mem", mem0, 0);
    chk("rst_wb", wb0, 0);
    chk("rst_cnt", if0.illegal_cnt, 0);
    rst_n = 1'b1;

    // LW then ADD, then bubbles
    drive(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b0);
    chk("lw_imm", if0.imm_src_d, 3'b000);
    chk("lw_ill", if0.illegal_d, 0);
    tick();
    chk("lw_ex", ex0, ew(1, 0, 0, 0, 0, 1, 3'b000, 2'b01));
    drive(1'b1, RT, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("add_ex", ex0, ew(1, 0, 0, 0, 0, 0, 3'b000, 2'b00));
    chk("lw_mem", mem0, 4'b1001);
    drive(1'b0, BAD, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("bubble_ill", if0.illegal_d, 0);
    tick();
    chk("lw_wb", wb0, 3'b101);
    chk("bubble_ex", ex0, 0);
    tick();
    chk("add_wb", wb0, 3'b100);

    // ALU decode
    drive(1'b1, RT, 3'b000, 1'b1, 1'b0, 1'b0); tick();
    chk("sub_ex", ex0, ew(1, 0, 0, 0, 0, 0, 3'b001, 2'b00));
    drive(1'b1, IT, 3'b000, 1'b1, 1'b0, 1'b0); tick();
    chk("addi_ex", ex0, ew(1, 0, 0, 0, 0, 1, 3'b000, 2'b00));
    drive(1'b1, RT, 3'b111, 1'b0, 1'b0, 1'b0); tick();
    chk("and_ex", ex0, ew(1, 0, 0, 0, 0, 0, 3'b010, 2'b00));
    drive(1'b1, IT, 3'b010, 1'b0, 1'b0, 1'b0); tick();
    chk("slti_ex", ex0, ew(1, 0, 0, 0, 0, 1, 3'b101, 2'b00));
    drive(1'b1, RT, 3'b110, 1'b1, 1'b0, 1'b0); tick();
    chk("or_ex", ex0, ew(1, 0, 0, 0, 0, 0, 3'b011, 2'b00));

    // Stall holds EX, MEM duplicates; stall+flush empties EX without counting
    drive(1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b0);
    chk("sw_imm", if0.imm_src_d, 3'b001);
    tick();
    chk("sw_ex", ex0, ew(0, 1, 0, 0, 0, 1, 3'b000, 2'b00));
    drive(1'b1, LUI, 3'b000, 1'b0, 1'b1, 1'b0);
    chk("stall_imm", if0.imm_src_d, 3'b100);
    tick();
    chk("stall1_ex", ex0, ew(0, 1, 0, 0, 0, 1, 3'b000, 2'b00));
    chk("stall1_mem", mem0, 4'b0100);
    tick();
    chk("stall2_ex", ex0, ew(0, 1, 0, 0, 0, 1, 3'b000, 2'b00));
    chk("stall2_mem", mem0, 4'b0100);
    drive(1'b1, BAD, 3'b000, 1'b0, 1'b1, 1'b1);
    chk("sf_ill", if0.illegal_d, 1);
    tick();
    chk("sf_ex", ex0, 0);
    chk("sf_mem", mem0, 4'b0100);
    chk("sf_cnt", if0.illegal_cnt, 0);
    drive(1'b0, 7'b0, 3'b000, 1'b0, 1'b0, 1'b0); tick();
    chk("sf_mem2", mem0, 0);

    // Illegal encodings and disabled features
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, BAD, 3'b000, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("bad_cnt0", if0.illegal_cnt, 3);
    chk("bad_ex", ex0, 0);
    drive(1'b1, JAL, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("jal_imm", if0.imm_src_d, 3'b011);
    chk("jal_ill1", if1.illegal_d, 1);
    tick();
    chk("jal_ex", ex0, ew(1, 0, 0, 1, 0, 0, 3'b000, 2'b10));
    chk("jal_ex_dis", ex1, 0);
    chk("jal_cnt1", if1.illegal_cnt, 4);
    chk("jal_cnt0", if0.illegal_cnt, 3);
    drive(1'b1, LUI, 3'b000, 1'b0, 1'b0, 1'b0); tick();
    chk("lui_ex", ex0, ew(1, 0, 0, 0, 0, 0, 3'b000, 2'b11));
    chk("lui_cnt1", if1.illegal_cnt, 5);
    drive(1'b1, JALR, 3'b001, 1'b0, 1'b0, 1'b0);
    chk("jalr1_ill", if0.illegal_d, 1);
    tick();
    chk("jalr1_ex", ex0, 0);
    drive(1'b1, BEQ, 3'b001, 1'b0, 1'b0, 1'b0); tick();
    chk("ill_cnt0", if0.illegal_cnt, 5);
    chk("ill_cnt1", if1.illegal_cnt, 7);
    chk("sat_cnt2", if2.illegal_cnt, 3);

    drive(1'b1, JALR, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("jalr_imm", if0.imm_src_d, 3'b000);
    chk("jalr_ill", if0.illegal_d, 0);
    tick();
    chk("jalr_ex", ex0, ew(1, 0, 0, 1, 1, 1, 3'b000, 2'b10));
    chk("jalr_ex_dis", ex1, 0);
    drive(1'b1, BEQ, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("beq_imm", if0.imm_src_d, 3'b010);
    tick();
    chk("beq_ex", ex0, ew(0, 0, 1, 0, 0, 0, 3'b001, 2'b00));

    // Asynchronous reset with a live pipeline
    drive(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("pre_rst_wb", wb0, 3'b101);
    rst_n = 1'b0;
    #1;
    chk("arst_ex", ex0, 0);
    chk("arst_mem", mem0, 0);
    chk("arst_wb", wb0, 0);
    chk("arst_cnt0", if0.illegal_cnt, 0);
    chk("arst_cnt2", if2.illegal_cnt, 0);
    tick();
    chk("arst_hold_wb", wb0, 0);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
